// File: rtl/rv32i_pkg.sv
// Shared register-file sizing constants for the RV32I integer core.
// Holds the default data width, register count and read-port count used as
// parameter defaults; ports stay parameter-sized so other configurations work.
package rv32i_pkg;

  localparam int RV32I_NREGS = 32;          // architectural integer registers
  localparam int XLEN_DEF    = 32;
  localparam int NREGS_DEF   = RV32I_NREGS;
  localparam int NRD_DEF     = 2;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set at issue, cleared at writeback.
// Ports: clk/rst_n; we0/wa0, we1/wa1 clear; iss_v/iss_rd set; flush clears all;
// busy_vec is the registered state (one-cycle update, no backpressure).
module rf_scoreboard #(
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic             iss_v,
  input  logic [AW-1:0]    iss_rd,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Order matters: clears first, then the issue set (the newer producer wins
  // over a retiring one on the same register), then flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (we0) busy_d[wa0] = 1'b0;
    if (we1) busy_d[wa1] = 1'b0;
    if (iss_v && !((ZERO_REG != 0) && (iss_rd == '0))) busy_d[iss_rd] = 1'b1;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two write ports, NRD write-first combinational read ports
// and an issue/writeback busy scoreboard (rf_scoreboard).
// Ports: rd_addr/rd_data/rd_busy per read port; we*/wa*/wd* writes; iss_v/iss_rd
// mark busy; flush clears busy; busy_vec exposes the scoreboard. Reads 0 cycles,
// writes/issue 1 cycle; no backpressure.
module regfile_sb
  import rv32i_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [XLEN-1:0]   wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [XLEN-1:0]   wd1,
  input  logic              iss_v,
  input  logic [AW-1:0]     iss_rd,
  input  logic              flush,
  output logic [NREGS-1:0]  busy_vec
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Port 1 is checked first so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (!((ZERO_REG != 0) && (r == 0))) begin
          if (we1 && (wa1 == AW'(r)))      regs_q[r] <= wd1;
          else if (we0 && (wa0 == AW'(r))) regs_q[r] <= wd0;
        end
      end
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .we0      (we0),
    .wa0      (wa0),
    .we1      (we1),
    .wa1      (wa1),
    .iss_v    (iss_v),
    .iss_rd   (iss_rd),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit0;
    logic          hit1;
    logic          is_zero;

    assign ra      = rd_addr[k*AW +: AW];
    assign hit0    = we0 && (wa0 == ra);
    assign hit1    = we1 && (wa1 == ra);
    assign is_zero = (ZERO_REG != 0) && (ra == '0);

    // Write-first bypass so a consumer in the writeback cycle sees new data.
    assign rd_data[k*XLEN +: XLEN] = is_zero ? '0    :
                                     hit1    ? wd1   :
                                     hit0    ? wd0   : regs_q[ra];

    // A writeback this cycle already retires the producer; a same-cycle issue
    // is not visible until the next edge.
    assign rd_busy[k] = !is_zero && busy_vec[ra] && !hit0 && !hit1;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks of regfile_sb (default 32x32, 2 read ports, x0 hard-wired)
// plus a 16x64, 3-read-port instance with an ordinary register 0.
// Inputs change on the falling edge; outputs are sampled 1ns after that.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: defaults
  logic [9:0]  a_rd_addr = '0;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_we0 = 1'b0, a_we1 = 1'b0, a_iss_v = 1'b0, a_flush = 1'b0;
  logic [4:0]  a_wa0 = '0, a_wa1 = '0, a_iss_rd = '0;
  logic [31:0] a_wd0 = '0, a_wd1 = '0;
  logic [31:0] a_busy_vec;

  regfile_sb u_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .we0(a_we0), .wa0(a_wa0), .wd0(a_wd0),
    .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1),
    .iss_v(a_iss_v), .iss_rd(a_iss_rd), .flush(a_flush),
    .busy_vec(a_busy_vec)
  );

  // Instance B: NRD=3, NREGS=16, XLEN=64, register 0 ordinary
  logic [11:0]  b_rd_addr = '0;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic         b_we0 = 1'b0, b_we1 = 1'b0, b_iss_v = 1'b0, b_flush = 1'b0;
  logic [3:0]   b_wa0 = '0, b_wa1 = '0, b_iss_rd = '0;
  logic [63:0]  b_wd0 = '0, b_wd1 = '0;
  logic [15:0]  b_busy_vec;
  logic [63:0]  b_model [16];

  regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0),
    .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1),
    .iss_v(b_iss_v), .iss_rd(b_iss_rd), .flush(b_flush),
    .busy_vec(b_busy_vec)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_idle();
    a_we0 = 1'b0; a_we1 = 1'b0; a_iss_v = 1'b0; a_flush = 1'b0;
  endtask

  // Advance to the next falling edge (one rising edge passes).
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // Power-on reset, with addresses pointing at ordinary registers
    a_rd_addr = {5'd6, 5'd5};
    #1;
    step(); #1;
    chk("rst_rd_data", a_rd_data, 64'h0);
    chk("rst_rd_busy", a_rd_busy, 64'h0);
    chk("rst_busy_vec", a_busy_vec, 64'h0);
    step();
    rst_n = 1'b1;

    // Write x5 = DEADBEEF, issue x2 for a nonzero scoreboard
    a_we0 = 1'b1; a_wa0 = 5'd5; a_wd0 = 32'hDEADBEEF;
    a_iss_v = 1'b1; a_iss_rd = 5'd2;
    step(); a_idle(); #1;
    chk("x5_written", a_rd_data[31:0], 64'hDEADBEEF);
    chk("busy2_set", a_busy_vec, 64'h4);

    // Mid-run asynchronous reset between clock edges, with traffic pending
    a_we0 = 1'b1; a_wa0 = 5'd6; a_wd0 = 32'h1234;
    a_iss_v = 1'b1; a_iss_rd = 5'd8; a_flush = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_x5", a_rd_data[31:0], 64'h0);
    chk("async_rst_busy", a_busy_vec, 64'h0);
    step();
    rst_n = 1'b1; a_idle();
    #1;
    chk("post_rst_x5", a_rd_data[31:0], 64'h0);
    chk("post_rst_x6", a_rd_data[63:32], 64'h0);
    chk("post_rst_busy", a_busy_vec, 64'h0);

    // Dual write collision on x7; port 0 also reads x7, port 1 reads x8
    a_rd_addr = {5'd8, 5'd7};
    a_we0 = 1'b1; a_wa0 = 5'd7; a_wd0 = 32'h11;
    a_we1 = 1'b1; a_wa1 = 5'd7; a_wd1 = 32'h22;
    #1;
    chk("collide_bypass", a_rd_data[31:0], 64'h22);
    step(); a_idle();
    // wd0 bypass when only port 0 hits
    a_we0 = 1'b1; a_wa0 = 5'd8; a_wd0 = 32'h5A5A0008;
    a_we1 = 1'b1; a_wa1 = 5'd9; a_wd1 = 32'h0;
    #1;
    chk("collide_stored", a_rd_data[31:0], 64'h22);
    chk("bypass_wd0", a_rd_data[63:32], 64'h5A5A0008);
    step(); a_idle(); #1;
    chk("x8_stored", a_rd_data[63:32], 64'h5A5A0008);

    // Issue x3, then write it back while port 1 reads x3
    a_iss_v = 1'b1; a_iss_rd = 5'd3;
    a_rd_addr = {5'd3, 5'd7};
    #1;
    chk("rd_busy_ignores_iss", a_rd_busy, 64'h0);
    step(); a_idle(); #1;
    chk("rd_busy_x3", a_rd_busy, 64'h2);
    a_we0 = 1'b1; a_wa0 = 5'd3; a_wd0 = 32'hCAFE0001;
    #1;
    chk("bypass_x3", a_rd_data[63:32], 64'hCAFE0001);
    chk("rd_busy_wb", a_rd_busy, 64'h0);
    step(); a_idle(); #1;
    chk("busy3_clear", a_busy_vec, 64'h0);

    // Zero register: write and issue x0
    a_rd_addr = {5'd0, 5'd0};
    a_we0 = 1'b1; a_wa0 = 5'd0; a_wd0 = 32'hFFFFFFFF;
    a_iss_v = 1'b1; a_iss_rd = 5'd0;
    #1;
    chk("x0_bypass", a_rd_data, 64'h0);
    step(); a_idle(); #1;
    chk("x0_read", a_rd_data, 64'h0);
    chk("x0_busy", a_busy_vec, 64'h0);
    chk("x0_rd_busy", a_rd_busy, 64'h0);

    // Scoreboard: newer issue beats same-cycle writeback
    a_rd_addr = {5'd2, 5'd9};
    a_iss_v = 1'b1; a_iss_rd = 5'd9;
    step(); a_idle(); #1;
    chk("busy9_set", a_busy_vec, 64'h200);
    a_we1 = 1'b1; a_wa1 = 5'd9; a_wd1 = 32'h99;
    a_iss_v = 1'b1; a_iss_rd = 5'd9;
    #1;
    chk("rd_busy9_wb", a_rd_busy, 64'h0);
    step(); a_idle(); #1;
    chk("busy9_kept", a_busy_vec, 64'h200);
    chk("rd_busy9_kept", a_rd_busy, 64'h1);
    a_we0 = 1'b1; a_wa0 = 5'd9; a_wd0 = 32'h9A;
    step(); a_idle(); #1;
    chk("busy9_cleared", a_busy_vec, 64'h0);
    chk("x9_data", a_rd_data[31:0], 64'h9A);

    // Flush with x2 and x9 busy; same-cycle issue dropped, write kept
    a_iss_v = 1'b1; a_iss_rd = 5'd2;
    step();
    a_iss_rd = 5'd9;
    step(); a_idle(); #1;
    chk("busy_2_9", a_busy_vec, 64'h204);
    chk("rd_busy_2_9", a_rd_busy, 64'h3);
    a_flush = 1'b1;
    a_iss_v = 1'b1; a_iss_rd = 5'd4;
    a_we0 = 1'b1; a_wa0 = 5'd12; a_wd0 = 32'hABC;
    a_rd_addr = {5'd12, 5'd4};
    step(); a_idle(); #1;
    chk("flush_busy", a_busy_vec, 64'h0);
    chk("flush_write", a_rd_data[63:32], 64'hABC);

    // Instance B sweep: fill all 16 registers, two per cycle
    for (int i = 0; i < 8; i++) begin
      b_we0 = 1'b1; b_wa0 = 4'(2*i);   b_wd0 = {$urandom(), $urandom()};
      b_we1 = 1'b1; b_wa1 = 4'(2*i+1); b_wd1 = {$urandom(), $urandom()};
      b_model[2*i]   = b_wd0;
      b_model[2*i+1] = b_wd1;
      step();
    end
    b_we0 = 1'b0; b_we1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b_rd_addr = {4'((i+11)%16), 4'((i+5)%16), 4'(i)};
      #1;
      chk($sformatf("sweep_p0_r%0d", i), b_rd_data[63:0],    b_model[i]);
      chk($sformatf("sweep_p1_r%0d", i), b_rd_data[127:64],  b_model[(i+5)%16]);
      chk($sformatf("sweep_p2_r%0d", i), b_rd_data[191:128], b_model[(i+11)%16]);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
